regex_stream_matcher: RTL and testbench
=======================================

# regex_stream_matcher

Bit-serial multi-pattern matcher: the next generation of the single-pattern `regex` block, with runtime-programmable patterns. It deserialises characters from the one-bit `i_c` stream, runs NUM_PAT shift-and NFAs (literal characters plus single-character wildcard `?`) over each fixed-length line, and reports per line which patterns matched and at which character position. It sits between the line-record stream source and the match-report logging path.

## Interface
- CHAR_W, 7: bits per character, MSB first on `i_c`.
- CHARS_PER_LINE, 3: characters per line record (line = CHAR_W*CHARS_PER_LINE bits).
- PAT_LEN, 2: characters per pattern, 1..CHARS_PER_LINE.
- NUM_PAT, 2: number of independent patterns, 1..16.
- LCNT_W, 16: line counter width.

- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- i  in  1  bit valid; `i_c` is consumed only on edges where `i`=1.
- i_c  in  1  serial data bit.
- clr  in  1  abort the partial line: clears bit/char counters and NFA state; line_count unchanged.
- cfg_we  in  1  pattern-table write strobe.
- cfg_pat  in  clog2(NUM_PAT) (min 1)  pattern index.
- cfg_pos  in  clog2(PAT_LEN) (min 1)  character position within pattern.
- cfg_char  in  CHAR_W  literal character.
- cfg_wild  in  1  1 = position matches any character.
- cfg_en  in  1  pattern enable, written together with the entry.
- o  out  1  any pattern matched in the last completed line.
- match_vec  out  NUM_PAT  per-pattern match flags for the last completed line.
- match_pos  out  clog2(CHARS_PER_LINE) (min 1)  char index (0-based) of the earliest match completion.
- line_done  out  1  one-cycle pulse: line results updated.
- line_count  out  LCNT_W  completed lines since reset, wraps at 2^LCNT_W.

## Operation
- Deserialiser: shift register plus bit counter 0..CHAR_W-1; the character completes on the valid edge where the counter equals CHAR_W-1 and equals {shreg[CHAR_W-2:0], i_c}.
- Char counter 0..CHARS_PER_LINE-1; it advances on each completed character and wraps to 0 after the last character of the line.
- Per pattern p, state vector S_p[PAT_LEN-1:0]; on each completed char c: S_p <= ((S_p<<1)|1) & M_p(c), where M_p[k] = wild[p][k] or char[p][k]==c.
- Pattern p completes when the new S_p[PAT_LEN-1]=1 and en[p]=1; its sticky flag hit_p sets. The first completion of the line records its char index into pos_acc. When several patterns complete on the same char, that char index is recorded.
- At the last char of a line (results include completions on that char): match_vec <= hit (or-ed with that char's completions), o <= |that value, match_pos <= recorded index (0 if no match), line_done=1, line_count+1. Then S_p, hit and pos_acc clear, so matches never span lines.
- Pattern table: reset clears all en to 0, char to 0 and wild to 0. A write with cfg_pat >= NUM_PAT or cfg_pos >= PAT_LEN is ignored. A write is visible to the compare on the next edge; mid-line writes are allowed and apply from the next completed char.
- `i`=0 holds all state (pause); there is no timeout.
- `clr`=1 overrides any bit arriving on the same edge (that bit is dropped). Outputs keep their previous-line values.
- Disabled pattern: its S_p still updates, but it never sets hit; enabling it mid-line can therefore report a match that started earlier in the line.

## Timing
- Reset values: o=0, match_vec=0, match_pos=0, line_done=0, line_count=0; all counters, S_p, hit and pattern table cleared. Reset asserted mid-line discards the partial line.
- Latency: the results are registered on the edge that samples the line's last bit. line_done is high for exactly the following cycle. o, match_vec and match_pos hold until the next line_done.
- Throughput: one bit per clock with `i` held high; back-to-back lines need no gap.
- Priority on one edge: reset > clr > data bit. A cfg write and a data bit on the same edge: the compare uses the old table.

## Test plan
- CHAR_W=7, CHARS_PER_LINE=3, PAT_LEN=2, NUM_PAT=2; p0="ab" (0x61,0x62), p1="?c" (wild, 0x63), both enabled. Line "xab" (0x78,0x61,0x62) -> line_done one cycle after the 21st bit, o=1, match_vec=01, match_pos=2, line_count=1.
- Line "abc" -> match_vec=11, match_pos=1. Line "xyz" -> o=0, match_vec=00, match_pos=0.
- Cross-line: "xxa" then "bxx" -> both lines o=0; line_count=2.
- Pause: "xab" with `i`=0 for 5 cycles inside char 1 and at a char boundary -> same result as the unpaused case, line_done delayed by 5 cycles.
- Disable p0 (cfg_en=0), send "abc" -> match_vec=10, match_pos=2. A write with cfg_pat=3 leaves the table unchanged.
- Reset after 10 bits of a line, then reprogram and send "xab" -> o=1, line_count=1; outputs are 0 during and right after reset. `clr` after 10 bits, then "xab" -> o=1, line_count increments by exactly 1.

Source files
------------

// File: rtl/regex_stream_matcher.sv
// Bit-serial multi-pattern matcher: deserialises characters from a one-bit stream and runs
// NUM_PAT shift-and NFAs (literals plus '?' wildcard) over fixed-length line records.
module regex_stream_matcher #(
  parameter int CHAR_W         = 7,
  parameter int CHARS_PER_LINE = 3,
  parameter int PAT_LEN        = 2,
  parameter int NUM_PAT        = 2,
  parameter int LCNT_W         = 16,
  localparam int PW  = (NUM_PAT > 1)        ? $clog2(NUM_PAT)        : 1,
  localparam int LW  = (PAT_LEN > 1)        ? $clog2(PAT_LEN)        : 1,
  localparam int MPW = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1,
  localparam int BW  = (CHAR_W > 1)         ? $clog2(CHAR_W)         : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i,
  input  logic              i_c,
  input  logic              clr,
  input  logic              cfg_we,
  input  logic [PW-1:0]     cfg_pat,
  input  logic [LW-1:0]     cfg_pos,
  input  logic [CHAR_W-1:0] cfg_char,
  input  logic              cfg_wild,
  input  logic              cfg_en,
  output logic              o,
  output logic [NUM_PAT-1:0] match_vec,
  output logic [MPW-1:0]    match_pos,
  output logic              line_done,
  output logic [LCNT_W-1:0] line_count
);

  logic [NUM_PAT-1:0][PAT_LEN-1:0][CHAR_W-1:0] pat_char;
  logic [NUM_PAT-1:0][PAT_LEN-1:0]             pat_wild;
  logic [NUM_PAT-1:0]                          pat_en;

  logic [CHAR_W-2:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [MPW-1:0]    char_cnt;
  logic [NUM_PAT-1:0][PAT_LEN-1:0] s_q, s_nxt, mvec;
  logic [NUM_PAT-1:0] hit, comp, hit_all;
  logic [MPW-1:0]     pos_acc;
  logic               found;

  logic [CHAR_W-1:0] cur_char;
  logic              char_done, last_char;

  assign cur_char  = {shreg, i_c};
  assign char_done = i && !clr && (bit_cnt == BW'(CHAR_W-1));
  assign last_char = (char_cnt == MPW'(CHARS_PER_LINE-1));
  assign hit_all   = hit | comp;

  // One shift-and NFA per pattern; S keeps advancing even while the pattern is disabled.
  for (genvar gp = 0; gp < NUM_PAT; gp++) begin : g_pat
    for (genvar gk = 0; gk < PAT_LEN; gk++) begin : g_pos
      assign mvec[gp][gk] = pat_wild[gp][gk] | (pat_char[gp][gk] == cur_char);
    end
    assign s_nxt[gp] = ((s_q[gp] << 1) | PAT_LEN'(1)) & mvec[gp];
    assign comp[gp]  = s_nxt[gp][PAT_LEN-1] & pat_en[gp];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_char   <= '0;
      pat_wild   <= '0;
      pat_en     <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      char_cnt   <= '0;
      s_q        <= '0;
      hit        <= '0;
      pos_acc    <= '0;
      found      <= 1'b0;
      o          <= 1'b0;
      match_vec  <= '0;
      match_pos  <= '0;
      line_done  <= 1'b0;
      line_count <= '0;
    end else begin
      line_done <= 1'b0;
      // Table writes land after this edge's compare, which still sees the old entry.
      if (cfg_we && (int'(cfg_pat) < NUM_PAT) && (int'(cfg_pos) < PAT_LEN)) begin
        pat_char[cfg_pat][cfg_pos] <= cfg_char;
        pat_wild[cfg_pat][cfg_pos] <= cfg_wild;
        pat_en[cfg_pat]            <= cfg_en;
      end
      if (clr) begin
        bit_cnt  <= '0;
        char_cnt <= '0;
        s_q      <= '0;
        hit      <= '0;
        pos_acc  <= '0;
        found    <= 1'b0;
      end else if (i) begin
        shreg   <= cur_char[CHAR_W-2:0];
        bit_cnt <= char_done ? '0 : bit_cnt + 1'b1;
        if (char_done) begin
          if (last_char) begin
            match_vec  <= hit_all;
            o          <= |hit_all;
            match_pos  <= (|hit_all) ? (found ? pos_acc : char_cnt) : '0;
            line_done  <= 1'b1;
            line_count <= line_count + 1'b1;
            char_cnt   <= '0;
            s_q        <= '0;
            hit        <= '0;
            pos_acc    <= '0;
            found      <= 1'b0;
          end else begin
            char_cnt <= char_cnt + 1'b1;
            s_q      <= s_nxt;
            hit      <= hit_all;
            if ((|comp) && !found) begin
              pos_acc <= char_cnt;
              found   <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regex_stream_matcher.sv
// Scoreboard bench: directed lines push expected results; a monitor pops on line_done.
module tb_regex_stream_matcher;

  localparam logic [6:0] CH_A = 7'h61, CH_B = 7'h62, CH_C = 7'h63;
  localparam logic [6:0] CH_X = 7'h78, CH_Y = 7'h79, CH_Z = 7'h7a;

  logic clk = 1'b0, reset, i, i_c, clr, cfg_we, cfg_wild, cfg_en, cfg_we3;
  logic [0:0] cfg_pat, cfg_pos;
  logic [1:0] cfg_pat3;
  logic [6:0] cfg_char;
  logic o, line_done, o_3, line_done_3;
  logic [1:0] match_vec, match_pos, match_pos_3;
  logic [2:0] match_vec_3;
  logic [15:0] line_count, line_count_3;

  typedef struct {
    logic o; logic [1:0] vec; logic [1:0] pos; logic [15:0] lcnt; int cyc;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int cyc = 0, n_cmp = 0, n_bad = 0, n_done = 0, n_push = 0, exp_lcnt = 0;

  regex_stream_matcher u_dut (
    .clk(clk), .reset(reset), .i(i), .i_c(i_c), .clr(clr),
    .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_pos(cfg_pos), .cfg_char(cfg_char),
    .cfg_wild(cfg_wild), .cfg_en(cfg_en),
    .o(o), .match_vec(match_vec), .match_pos(match_pos),
    .line_done(line_done), .line_count(line_count)
  );

  // Three-pattern copy with pattern 2 left disabled; used to exercise an out-of-range index.
  regex_stream_matcher #(.NUM_PAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .i(i), .i_c(i_c), .clr(clr),
    .cfg_we(cfg_we3), .cfg_pat(cfg_pat3), .cfg_pos(cfg_pos), .cfg_char(cfg_char),
    .cfg_wild(cfg_wild), .cfg_en(cfg_en),
    .o(o_3), .match_vec(match_vec_3), .match_pos(match_pos_3),
    .line_done(line_done_3), .line_count(line_count_3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (line_done) begin
      n_done++;
      if (q.size() == 0) chk("unexpected_line_done", 32'd1, 32'd0);
      else begin
        m = q.pop_front();
        chk("o", {31'd0, o}, {31'd0, m.o});
        chk("match_vec", {30'd0, match_vec}, {30'd0, m.vec});
        chk("match_pos", {30'd0, match_pos}, {30'd0, m.pos});
        chk("line_count", {16'd0, line_count}, {16'd0, m.lcnt});
        chk("done_cycle", cyc, m.cyc);
        chk("dut3_vec", {29'd0, match_vec_3}, {29'd0, 1'b0, m.vec});
        chk("dut3_done", {31'd0, line_done_3}, 32'd1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); i = 1'b0; end
  endtask

  task automatic send_char(input logic [6:0] c, input int nb = 7, input int pb = -1);
    for (int k = 0; k < nb; k++) begin
      if (k == pb) idle(5);
      @(negedge clk); i = 1'b1; i_c = c[6-k];
    end
  endtask

  // Called right after the line's last bit is driven; that bit is sampled on the next edge.
  task automatic push_exp(input logic eo, input logic [1:0] ev, input logic [1:0] ep);
    exp_t e;
    exp_lcnt++;
    n_push++;
    e.o = eo; e.vec = ev; e.pos = ep; e.lcnt = 16'(exp_lcnt); e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic send_line(input logic [6:0] c0, c1, c2,
                           input logic eo, input logic [1:0] ev, input logic [1:0] ep);
    send_char(c0); send_char(c1); send_char(c2);
    push_exp(eo, ev, ep);
  endtask

  task automatic wr(input int p, input int pos, input logic [6:0] ch, input logic w, input logic en);
    @(negedge clk);
    i = 1'b0; cfg_we = 1'b1; cfg_we3 = 1'b1;
    cfg_pat = 1'(p); cfg_pat3 = 2'(p); cfg_pos = 1'(pos);
    cfg_char = ch; cfg_wild = w; cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0; cfg_we3 = 1'b0;
  endtask

  task automatic program_std();
    wr(0, 0, CH_A, 1'b0, 1'b1);
    wr(0, 1, CH_B, 1'b0, 1'b1);
    wr(1, 0, 7'h00, 1'b1, 1'b1);
    wr(1, 1, CH_C, 1'b0, 1'b1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_o"}, {31'd0, o}, 32'd0);
    chk({nm, "_vec"}, {30'd0, match_vec}, 32'd0);
    chk({nm, "_pos"}, {30'd0, match_pos}, 32'd0);
    chk({nm, "_done"}, {31'd0, line_done}, 32'd0);
    chk({nm, "_lcnt"}, {16'd0, line_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i = 1'b0; i_c = 1'b0; clr = 1'b0;
    cfg_we = 1'b0; cfg_we3 = 1'b0; cfg_pat = '0; cfg_pat3 = '0; cfg_pos = '0;
    cfg_char = '0; cfg_wild = 1'b0; cfg_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    program_std();

    send_line(CH_X, CH_A, CH_B, 1'b1, 2'b01, 2'd2);
    send_line(CH_A, CH_B, CH_C, 1'b1, 2'b11, 2'd1);
    send_line(CH_X, CH_Y, CH_Z, 1'b0, 2'b00, 2'd0);
    send_line(CH_X, CH_X, CH_A, 1'b0, 2'b00, 2'd0);
    send_line(CH_B, CH_X, CH_X, 1'b0, 2'b00, 2'd0);
    idle(3);

    // Pause inside char 1, then at the boundary before char 2.
    send_char(CH_X); send_char(CH_A, 7, 3); send_char(CH_B);
    push_exp(1'b1, 2'b01, 2'd2);
    send_char(CH_X); send_char(CH_A); idle(5); send_char(CH_B);
    push_exp(1'b1, 2'b01, 2'd2);

    wr(0, 0, CH_A, 1'b0, 1'b0);
    send_line(CH_A, CH_B, CH_C, 1'b1, 2'b10, 2'd2);
    // Index 3 does not exist in the three-pattern copy.
    @(negedge clk);
    i = 1'b0; cfg_we3 = 1'b1; cfg_pat3 = 2'd3; cfg_pos = 1'b0;
    cfg_char = CH_X; cfg_wild = 1'b1; cfg_en = 1'b1;
    @(negedge clk);
    cfg_we3 = 1'b0;
    send_line(CH_A, CH_B, CH_C, 1'b1, 2'b10, 2'd2);

    // Enabling p0 mid-line still reports the match that began while it was disabled.
    send_char(CH_X); send_char(CH_A);
    wr(0, 0, CH_A, 1'b0, 1'b1);
    send_char(CH_B);
    push_exp(1'b1, 2'b01, 2'd2);
    idle(3);

    // Reset mid-line after 10 bits.
    send_char(CH_X); send_char(CH_A, 3);
    @(negedge clk); reset = 1'b1; i = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");
    exp_lcnt = 0;
    program_std();
    send_line(CH_X, CH_A, CH_B, 1'b1, 2'b01, 2'd2);
    idle(3);

    // clr after 10 bits; the bit on the clr edge is dropped.
    send_char(CH_X); send_char(CH_A, 3);
    @(negedge clk); clr = 1'b1; i = 1'b1; i_c = 1'b1;
    @(negedge clk); clr = 1'b0; i = 1'b0;
    chk("clr_hold_o", {31'd0, o}, 32'd1);
    chk("clr_hold_lcnt", {16'd0, line_count}, exp_lcnt);
    send_line(CH_X, CH_A, CH_B, 1'b1, 2'b01, 2'd2);

    idle(6);
    chk("queue_drained", q.size(), 32'd0);
    chk("done_pulses", n_done, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
